// File: rtl/vga_capture_pkg.sv
// Shared types and default timing for the VGA capture block.
package vga_capture_pkg;

    typedef enum logic {
        WAIT_VSYNC = 1'b0,
        CAPTURE    = 1'b1
    } state_e;

    localparam int DEF_CLK_DIV_VAL    = 4;
    localparam int DEF_H_ACTIVE_START = 144;
    localparam int DEF_H_IMAGE        = 640;
    localparam int DEF_H_END          = 800;
    localparam int DEF_V_ACTIVE_START = 35;
    localparam int DEF_V_IMAGE        = 480;
    localparam int DEF_FIFO_DEPTH     = 16;

    localparam int         CNT_W   = 10;
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } pix_t;

endpackage

// File: rtl/vga_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry reads as zero while empty.
module vga_capture_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd = rd_en && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_wr = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
        rd_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/vga_capture.sv
// VGA input sampler: divider, h/v counters and capture FSM feeding an AXI-Stream FIFO.
// Define VGA_CAPTURE_SYNC_CHECK_EN to enable line-length checking and the desync flag.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int CLK_DIV_VAL    = DEF_CLK_DIV_VAL,
    parameter int H_ACTIVE_START = DEF_H_ACTIVE_START,
    parameter int H_IMAGE        = DEF_H_IMAGE,
    parameter int H_END          = DEF_H_END,
    parameter int V_ACTIVE_START = DEF_V_ACTIVE_START,
    parameter int V_IMAGE        = DEF_V_IMAGE,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb,
    output logic [15:0] mdata,
    output logic        mvalid,
    input  logic        mready,
    output logic        mlast,
    output logic        overflow,
    output logic        desync
);
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
    localparam bit SYNC_CHECK = 1'b1;
`else
    localparam bit SYNC_CHECK = 1'b0;
`endif

    localparam int              DIV_W    = (CLK_DIV_VAL > 1) ? $clog2(CLK_DIV_VAL) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_VAL - 1);
    localparam logic [10:0] H_LO   = 11'(H_ACTIVE_START);
    localparam logic [10:0] H_HI   = 11'(H_ACTIVE_START + H_IMAGE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE_START + H_IMAGE - 1);
    localparam logic [10:0] V_LO   = 11'(V_ACTIVE_START);
    localparam logic [10:0] V_HI   = 11'(V_ACTIVE_START + V_IMAGE);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE_START + V_IMAGE - 1);
    localparam logic [10:0] H_LEN  = 11'(H_END);

    logic [DIV_W-1:0] div_q, div_d;
    logic             hs_prev_q, hs_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, h_cnt_next;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d, v_cnt_next;
    state_e           state_q, state_d;
    logic             overflow_q, overflow_d;
    logic             desync_q, desync_d;

    logic             clk_en, hs_fall, vs_fall;
    logic [10:0]      h_ext, v_ext;
    logic             active, is_last, line_bad;
    logic             push, pop, drop;
    logic             fifo_full, fifo_empty;
    pix_t             wr_pix, rd_pix;

    always_comb begin
        clk_en  = (div_q == DIV_LAST);
        div_d   = clk_en ? '0 : div_q + 1'b1;
        hs_fall = hs_prev_q & ~hsync;
        vs_fall = vs_prev_q & ~vsync;

        h_cnt_next = hs_fall ? '0 : (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 1'b1;
        v_cnt_next = vs_fall ? '0 : hs_fall ? v_cnt_q + 1'b1 : v_cnt_q;

        // Activity is judged on the counter values this sample will produce.
        h_ext   = {1'b0, h_cnt_next};
        v_ext   = {1'b0, v_cnt_next};
        active  = (h_ext >= H_LO) && (h_ext < H_HI) && (v_ext >= V_LO) && (v_ext < V_HI);
        is_last = (h_ext == H_LAST) && (v_ext == V_LAST);

        line_bad = SYNC_CHECK && (state_q == CAPTURE) && hs_fall &&
                   (({1'b0, h_cnt_q} + 11'd1) != H_LEN);

        push = clk_en && (state_q == CAPTURE) && active && !line_bad;
        pop  = !fifo_empty && mready;
        drop = push && fifo_full && !pop;

        wr_pix.data = rgb;
        wr_pix.last = is_last;

        hs_prev_d = clk_en ? hsync      : hs_prev_q;
        vs_prev_d = clk_en ? vsync      : vs_prev_q;
        h_cnt_d   = clk_en ? h_cnt_next : h_cnt_q;
        v_cnt_d   = clk_en ? v_cnt_next : v_cnt_q;

        state_d    = state_q;
        overflow_d = overflow_q;
        desync_d   = desync_q;
        if (clk_en) begin
            case (state_q)
                WAIT_VSYNC: if (vs_fall) state_d = CAPTURE;
                CAPTURE: begin
                    if (line_bad) begin
                        desync_d = 1'b1;
                        state_d  = WAIT_VSYNC;
                    end else if (drop) begin
                        overflow_d = 1'b1;
                        state_d    = WAIT_VSYNC;
                    end
                end
                default: state_d = WAIT_VSYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= '0;
            hs_prev_q  <= 1'b1;
            vs_prev_q  <= 1'b1;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            state_q    <= WAIT_VSYNC;
            overflow_q <= 1'b0;
            desync_q   <= 1'b0;
        end else begin
            div_q      <= div_d;
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            desync_q   <= desync_d;
        end
    end

    vga_capture_fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (push),
        .wr_data (wr_pix),
        .rd_en   (pop),
        .rd_data (rd_pix),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign mvalid   = !fifo_empty;
    assign mdata    = rd_pix.data;
    assign mlast    = rd_pix.last;
    assign overflow = overflow_q;
    assign desync   = desync_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down 32x8 raster with a 20x4 image.
module tb_vga_capture;
    localparam int DIV   = 2;
    localparam int HS    = 6;
    localparam int HI    = 20;
    localparam int HE    = 32;
    localparam int VS    = 2;
    localparam int VI    = 4;
    localparam int DEPTH = 16;
    localparam int LINES = 8;
    localparam int NPIX  = HI * VI;

    logic        clk = 1'b0, reset = 1'b0;
    logic        hsync = 1'b1, vsync = 1'b1, mready = 1'b0;
    logic [15:0] rgb = '0;
    logic [15:0] mdata;
    logic        mvalid, mlast, overflow, desync;

    int tests = 0, fails = 0;
    int rdy_mode = 0, zeros = 0, stab_err = 0;

    typedef struct { logic [15:0] d; logic l; } beat_t;
    beat_t q[$];

    logic        stalled = 1'b0, st_l = 1'b0;
    logic [15:0] st_d = '0;

    vga_capture #(
        .CLK_DIV_VAL(DIV), .H_ACTIVE_START(HS), .H_IMAGE(HI), .H_END(HE),
        .V_ACTIVE_START(VS), .V_IMAGE(VI), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .mdata(mdata), .mvalid(mvalid), .mready(mready), .mlast(mlast),
        .overflow(overflow), .desync(desync)
    );

    always #5 clk = ~clk;

    // Beat collector and stall-stability watcher
    always @(negedge clk) begin
        if (stalled && mvalid && (mdata !== st_d || mlast !== st_l)) stab_err++;
        stalled = mvalid && !mready;
        st_d = mdata;
        st_l = mlast;
        if (mvalid && mready && reset) q.push_back('{mdata, mlast});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic smp(input logic hs, input logic vs, input logic [15:0] d);
        hsync = hs; vsync = vs; rgb = d;
        repeat (DIV) begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: mready = 1'b1;
                1: mready = 1'b0;
                default: begin
                    mready = (zeros >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    zeros  = mready ? 0 : zeros + 1;
                end
            endcase
        end
    endtask

    task automatic line(input int ln, input int len, input int h0);
        for (int h = h0; h < len; h++) begin
            logic [15:0] px;
            px = (ln >= VS && ln < VS + VI && h >= HS && h < HS + HI) ?
                 16'((ln - VS) * HI + (h - HS)) : 16'hBEEF;
            smp(h >= 4, ln >= 2, px);
        end
    endtask

    task automatic frame(input int first, input int short_ln);
        for (int ln = first; ln < LINES; ln++) line(ln, (ln == short_ln) ? 22 : HE, 0);
    endtask

    function automatic int n_last();
        int n = 0;
        foreach (q[i]) if (q[i].l) n++;
        return n;
    endfunction

    task automatic chk_frame(input string tag);
        int errs = 0;
        chk({tag, " beats"}, q.size(), NPIX);
        if (q.size() > 0) chk({tag, " first"}, 32'(q[0].d), 0);
        foreach (q[i]) if (q[i].d !== 16'(i) || q[i].l !== (i == NPIX - 1)) errs++;
        chk({tag, " seq"}, errs, 0);
        q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        repeat (4) @(posedge clk);
        #1;
        chk("rst mvalid", 32'(mvalid), 0);
        chk("rst mlast", 32'(mlast), 0);
        chk("rst mdata", 32'(mdata), 0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst desync", 32'(desync), 0);
        reset = 1'b1;

        // Mid-frame start: nothing until the next vsync fall
        rdy_mode = 0;
        frame(4, -1);
        chk("midframe beats", q.size(), 0);
        q.delete();

        frame(0, -1);
        chk_frame("frame1");
        frame(0, -1);
        chk_frame("frame2");

        rdy_mode = 2;
        frame(0, -1);
        rdy_mode = 0;
        chk_frame("random");
        chk("random overflow", 32'(overflow), 0);
        chk("random stable", stab_err, 0);

        // Line 3 cut to 22 samples
        frame(0, 3);
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
        chk("short beats", q.size(), 36);
        chk("short last", n_last(), 0);
        chk("short desync", 32'(desync), 1);
`else
        chk("short beats", q.size(), 76);
        chk("short last", n_last(), 1);
        chk("short desync", 32'(desync), 0);
`endif
        q.delete();
        frame(0, -1);
        chk_frame("after short");

        // Stall through the first active line: 16 fit, the 17th overflows
        line(0, HE, 0);
        line(1, HE, 0);
        rdy_mode = 1;
        line(2, HE, 0);
        rdy_mode = 0;
        for (int ln = 3; ln < LINES; ln++) line(ln, HE, 0);
        chk("ovf beats", q.size(), DEPTH);
        chk("ovf last", n_last(), 0);
        errs = 0;
        foreach (q[i]) if (q[i].d !== 16'(i)) errs++;
        chk("ovf seq", errs, 0);
        chk("ovf flag", 32'(overflow), 1);
        q.delete();
        frame(0, -1);
        chk_frame("after ovf");
        chk("ovf sticky", 32'(overflow), 1);
        chk("stall stable", stab_err, 0);

        // Reset pulse with six pixels queued
        rdy_mode = 1;
        line(0, HE, 0);
        line(1, HE, 0);
        line(2, 12, 0);
        chk("pre-reset mvalid", 32'(mvalid), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset mvalid", 32'(mvalid), 0);
        reset = 1'b1;
        rdy_mode = 0;
        line(2, HE, 12);
        for (int ln = 3; ln < LINES; ln++) line(ln, HE, 0);
        chk("post-reset beats", q.size(), 0);
        chk("post-reset overflow", 32'(overflow), 0);
        q.delete();
        frame(0, -1);
        chk_frame("post-reset frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
